// File: rtl/regfile_dump.sv
// regfile_dump - atomic snapshot of the register file, streamed one register per beat.
// Entry 0 always reads as zero (architectural x0) regardless of the live value.
module regfile_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] regs_in [NUM_REGS],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   snap_q [NUM_REGS];
  logic                    snap_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Snapshot storage needs no reset: it is only read after a load.
  always_ff @(posedge clk) begin
    if (snap_load) begin
      for (int i = 0; i < NUM_REGS; i++) snap_q[i] <= regs_in[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    snap_load = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_load = 1'b1;
          cnt_d     = '0;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_last  = (cnt_q == LAST_ADDR);
        out_data  = (cnt_q == '0) ? '0 : snap_q[cnt_q];
        if (out_ready) begin
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_addr = cnt_q;

endmodule

// File: tb/tb_regfile_dump.sv
// tb_regfile_dump - randomized bench with a queue-based reference model of the dump stream.
module tb_regfile_dump;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] regs_in [NR];
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;
  logic          busy;
  logic          done;

  regfile_dump #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .regs_in(regs_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int xfers  = 0;
  int dones  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the pending beats of the current dump, plus a done flag.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  beat_t q[$];
  bit    m_done = 1'b0;

  always @(negedge rst_n) begin
    q.delete();
    m_done = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (m_done) begin
        m_done = 1'b0;
      end else if (q.size() > 0) begin
        if (out_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) m_done = 1'b1;
        end
      end else if (start) begin
        for (int i = 0; i < NR; i++) begin
          beat_t b;
          b.a = AW'(i);
          b.d = (i == 0) ? '0 : regs_in[i];
          q.push_back(b);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("valid", out_valid, q.size() > 0);
    chk("busy", busy, (q.size() > 0) || m_done);
    chk("done", done, m_done);
    if (q.size() > 0) begin
      chk("addr", out_addr, q[0].a);
      chk("data", out_data, q[0].d);
      chk("last", out_last, q.size() == 1);
    end
    if (out_valid && out_ready) xfers++;
    if (done) dones++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_spec();
    for (int i = 0; i < NR; i++) regs_in[i] = 32'h1000_0000 + i;
    regs_in[0] = 32'hDEAD_BEEF;
  endtask

  initial begin
    int k;
    int stall;
    int d_at;
    int dumps;
    bit seen7;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    load_spec();
    tick();
    tick();
    chk("rst valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst addr", out_addr, 0);
    chk("rst data", out_data, 0);
    chk("rst last", out_last, 0);
    rst_n = 1'b1;
    tick();

    // Full dump with ready held high.
    xfers = 0; dones = 0;
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("t1 first valid", out_valid, 1);
    chk("t1 first addr", out_addr, 0);
    chk("t1 x0 data", out_data, 0);
    k = 1;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk("t1 start-to-done", k, 33);
    chk("t1 transfers", xfers, 32);
    tick();
    tick();

    // Random backpressure, stall at addr 5, overwrite r7, re-start at addr 10.
    xfers = 0; dones = 0; stall = 0; seen7 = 1'b0;
    load_spec();
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    regs_in[7] = 32'hFFFF_FFFF;
    for (int n = 0; n < 500 && !done; n++) begin
      start = 1'b0;
      if (out_valid && out_addr == 5 && stall < 3) begin
        chk("t2 stall addr", out_addr, 5);
        chk("t2 stall data", out_data, 32'h1000_0005);
        out_ready = 1'b0;
        stall++;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (out_valid && out_addr == 7 && !seen7) begin
        chk("t3 r7 snapshot", out_data, 32'h1000_0007);
        seen7 = 1'b1;
      end
      if (out_valid && out_addr == 10) start = 1'b1;
      for (int i = 1; i < NR; i++) if (i != 7) regs_in[i] = $urandom;
      tick();
    end
    start = 1'b0;
    chk("t2 done seen", done, 1);
    tick();
    tick();
    chk("t2 transfers", xfers, 32);
    chk("t4 single done", dones, 1);
    chk("t2 stalls", stall, 3);

    // Reset mid-dump at addr 12.
    load_spec();
    out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 50 && out_addr != 12; n++) tick();
    chk("t5 reached 12", out_addr, 12);
    rst_n = 1'b0;
    #1;
    chk("t5 async valid", out_valid, 0);
    chk("t5 async busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t5 restart addr", out_addr, 0);
    chk("t5 restart valid", out_valid, 1);
    for (int n = 0; n < 100 && !done; n++) tick();
    chk("t5 done", done, 1);
    tick();

    // Start held high: back-to-back dumps with fresh snapshots.
    d_at = -1; dumps = 0;
    start = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 300 && dumps < 2; n++) begin
      tick();
      for (int i = 0; i < NR; i++) regs_in[i] = $urandom;
      if (done) d_at = n;
      if (out_valid && out_addr == 0 && d_at >= 0) begin
        chk("t6 gap", n - d_at, 2);
        d_at = -1;
        dumps++;
      end
    end
    chk("t6 dumps", dumps, 2);
    start = 1'b0;
    for (int n = 0; n < 100 && busy; n++) tick();
    chk("t6 idle", busy, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Reader-side counterpart to the CPU register file's full-array debug output.
- On `start`, takes one atomic snapshot of all architectural registers.
- Streams the snapshot one register per beat over a valid/ready interface to a debug/trace consumer (UART bridge, testbench monitor).
- The snapshot keeps writebacks that land during the dump out of the stream.

Parameters:
- DATA_WIDTH, 32, width of each register and of `out_data`.
- NUM_REGS, 32, number of registers snapshotted and streamed (must be ≥ 2 and ≤ 2^ADDR_WIDTH).
- ADDR_WIDTH, 5, width of `out_addr`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a dump; sampled only in IDLE.
- regs_in  input  DATA_WIDTH x NUM_REGS (unpacked array)  live register-file contents, index = register number.
- out_valid  output  1  beat valid.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  DATA_WIDTH  snapshotted register value.
- out_addr  output  ADDR_WIDTH  register number of the current beat.
- out_last  output  1  high on the beat with out_addr = NUM_REGS-1.
- busy  output  1  dump in progress (SEND or DONE).
- done  output  1  one-cycle pulse after the last beat transfers.

Behaviour:
- Reset: asynchronous assertion clears everything immediately, not waiting for clk.
  - State = IDLE; out_valid, out_last, busy, done = 0; out_addr = 0; out_data = 0.
  - Snapshot contents are don't-care.
  - Deassertion takes effect at the next rising edge.
- States: IDLE, SEND, DONE.
- IDLE:
  - If start = 1 at an edge: copy regs_in into the snapshot array, then go to SEND.
  - Snapshot entry 0 is forced to 0 (architectural x0), whatever regs_in[0] holds.
- SEND:
  - out_valid = 1, out_addr = beat counter, out_data = snapshot[counter], out_last = (counter == NUM_REGS-1), busy = 1.
  - First beat (addr 0) is visible in the cycle right after the start edge: 1-cycle latency.
  - A beat transfers at an edge where out_valid && out_ready; the counter then increments by 1.
  - While out_ready = 0, out_data, out_addr and out_last hold stable (no drop, no change).
  - Back-to-back transfers are supported: one beat per cycle when out_ready is held high.
  - When the out_last beat transfers, go to DONE; the counter returns to 0 and never wraps past NUM_REGS-1.
- DONE (exactly one cycle): done = 1, busy = 1, out_valid = 0; then go to IDLE.
- start is ignored in SEND and DONE; a new dump needs start high in IDLE.
- start held high continuously gives repeated dumps separated by the DONE cycle plus the IDLE cycle in which start is re-sampled.
- regs_in changes after the snapshot edge have no effect on the stream in progress.
- Reset asserted mid-dump: out_valid drops asynchronously; no further beats; a fresh start after reset begins again at addr 0.
- Full dump with out_ready held high takes NUM_REGS cycles in SEND plus 1 in DONE.
- Widths: the counter is ADDR_WIDTH bits; the last-beat compare uses NUM_REGS-1 truncated to ADDR_WIDTH.

Test Plan:
- Reset, then load regs_in[i] = 0x1000_0000 + i, regs_in[0] = 0xDEAD_BEEF; pulse start with out_ready = 1.
  - Beats are addr 0..31, data 0 then 0x1000_0001..0x1000_001F, with out_last only at addr 31.
  - done pulses in the cycle after beat 31; 33 cycles from start to done.
- Same load; toggle out_ready randomly (e.g. low 3 cycles at addr 5).
  - out_data = 0x1000_0005 and out_addr = 5 stay stable while stalled.
  - No beat is lost or duplicated; 32 transfers total.
- After start, overwrite regs_in[7] = 0xFFFF_FFFF during the dump.
  - Beat 7 still carries 0x1000_0007.
- Assert start again during SEND at addr 10.
  - No restart; the stream continues 11..31; done fires once.
- Assert rst_n = 0 mid-cycle at addr 12.
  - out_valid, busy = 0 immediately (before the next edge).
  - After release and a new start, the stream begins at addr 0.
- Hold start = 1 permanently with out_ready = 1.
  - Consecutive dumps are separated by the DONE cycle and one IDLE cycle.
  - Each dump restarts at addr 0 with a fresh snapshot.
